// File: rtl/mdu_pkg.sv
// Shared types for the RV32M iterative multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div sequencer.
interface mdu_sequencer_if #(parameter int XLEN = 32) ();
  logic            start;
  logic            flush;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (output start, flush, Funct3, SrcA, SrcB,
                  input  busy, done, Result);
  modport slave  (input  start, flush, Funct3, SrcA, SrcB,
                  output busy, done, Result);
endinterface

// File: rtl/mdu_sequencer.sv
// Radix-2 iterative RV32M unit: shift-add multiply, restoring divide on
// operand magnitudes, with sign correction applied once in FIX.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  mdu_sequencer_if.slave bus
);

  localparam int              CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode, evaluated only when a start is accepted in IDLE.
  mdu_op_t         op_in;
  logic            sgn_a_in, sgn_b_in, div_by_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign op_in       = mdu_op_t'(bus.Funct3);
  assign sgn_a_in    = bus.SrcA[XLEN-1] &
                       (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sgn_b_in    = bus.SrcB[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
  assign mag_a       = sgn_a_in ? -bus.SrcA : bus.SrcA;
  assign mag_b       = sgn_b_in ? -bus.SrcB : bus.SrcB;
  assign div_by_zero = bus.Funct3[2] && (bus.SrcB == '0);
  assign div_ovf     = (op_in inside {OP_DIV, OP_REM}) &&
                       (bus.SrcA == MIN_INT) && (bus.SrcB == '1);

  // One multiply step: conditionally add multiplicand into the high half, shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: remainder in the high half, dividend/quotient in the low half.
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              borrow;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_step;
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign borrow   = rem_diff[XLEN];
  assign rem_new  = borrow ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
  assign div_step = {rem_new, acc_q[XLEN-2:0], ~borrow};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_result = quo_fix;
      default:                       fix_result = rem_fix;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a latch.
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = op_in;
          sa_d  = sgn_a_in;
          sb_d  = sgn_b_in;
          cnt_d = '0;
          if (bus.Funct3[2]) begin
            opnd_d = mag_b;
            acc_d  = {{XLEN{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{XLEN{1'b0}}, mag_b};
          end
          if (div_by_zero) begin
            result_d = bus.Funct3[1] ? bus.SrcA : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = bus.Funct3[1] ? '0 : bus.SrcA;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An aborted op must leave Result untouched, even if it was in FIX.
    if (bus.flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.Result = result_q;

endmodule
